frame_pixel_streamer: RTL
=========================

Name: frame_pixel_streamer

Overview:
Source end of the raster pixel stream consumed by the gradient block. Reads an M x N 8-bit frame from a synchronous-read frame buffer in row-major raster order. Emits one pixel per cycle on pixel_out/valid, with optional idle gap cycles between rows. Controlled by a start/busy/done handshake from the system sequencer.

Parameters:
M, 5, frame rows
N, 5, frame columns
ADDR_W, 5, frame buffer address width; M*N <= 2**ADDR_W required
H_GAP, 0, idle cycles inserted after each row except the last (0..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  frame request; sampled only in IDLE
abort  in  1  terminate current frame; sampled while busy
mem_rd_en  out  1  frame buffer read enable
mem_addr  out  ADDR_W  frame buffer read address, row*N+col
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
pixel_out  out  8  streamed pixel
valid  out  1  pixel_out qualifier
sof  out  1  high with the first pixel of the frame
eol  out  1  high with the last pixel of each row
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame completion or abort
frame_cnt  out  16  completed (non-aborted) frames, wraps at 65535->0

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock and reset ports are named clk and rst.
- Reset values: all outputs are 0; state is IDLE; row, col and gap counters are 0.
- FSM states: IDLE, READ, GAP, DRAIN, DONE.
- IDLE:
  - start=1 -> READ on the next edge.
  - start is ignored in every other state.
- READ:
  - Each cycle drives mem_rd_en=1, mem_addr=row*N+col, then advances col.
  - At col=N-1: col->0, row++.
  - If H_GAP>0 and this is not the last row -> GAP.
  - At the last address (row=M-1, col=N-1) -> DRAIN.
- GAP: mem_rd_en=0 for exactly H_GAP cycles, then -> READ.
- DRAIN: one cycle waiting for the final read data, then -> DONE.
- DONE: one cycle, then -> IDLE.
- Output pipeline:
  - A read issued in cycle t returns mem_rdata in t+1.
  - pixel_out, valid, sof and eol are registered and visible in t+2.
  - sof and eol are carried through a 2-stage tag pipeline alongside the read.
- Latency: start high in cycle 0 (IDLE) -> first mem_rd_en in cycle 1 -> first valid in cycle 3.
- Valid pattern: N consecutive valid cycles per row, then H_GAP invalid cycles between rows, none after the last row. Total frame span is M*N + (M-1)*H_GAP valid-window cycles.
- busy: high from the cycle after start is accepted through the cycle of the last valid pixel.
- done and frame_cnt:
  - done pulses in the cycle after the last valid, the same cycle busy falls.
  - frame_cnt increments on that same edge.
- When valid=0, pixel_out holds its last value. sof and eol are 0 whenever valid=0.
- abort=1 in READ or GAP:
  - The read in that cycle is not issued; in-flight reads complete normally (at most 2 more valid pixels).
  - The FSM goes to DRAIN, then DONE; done pulses but frame_cnt is not incremented.
- abort is ignored in IDLE, DRAIN and DONE. abort and start together in IDLE: start wins.
- Degenerate sizes:
  - M=1: no GAP state is entered.
  - N=1: every pixel has eol=1.
  - The first pixel of a frame has sof=1, and also eol=1 when N=1.
- rst asserted mid-frame: the next edge clears all state and outputs; no done pulse; frame_cnt returns to 0.

Decomposition:
- Shared package (pixel_stream_pkg):
  - FSM state enum.
  - PIXEL_W=8 constant.
  - raster index function (row*N+col), also used by the gradient-side windowing logic.
- One sub-module, raster_addr_counter:
  - Row and column counters with synchronous clear and advance enable.
  - Outputs: last_col, last_row, addr.
- The FSM, gap counter and output pipeline stay in the top module.

Test Plan:
- Basic frame: M=N=5, H_GAP=0, memory[a]=a*3.
  - start at cycle 0 -> valid high in cycles 3..27 with pixel_out 0,3,...,72.
  - sof at cycle 3; eol at cycles 7,12,17,22,27.
  - done in cycle 28; frame_cnt=1.
- Row gap: H_GAP=2 -> valid in bursts of 5 with 2 idle cycles between.
  - Last pixel (72) at cycle 35; done at cycle 36.
  - No gap after row 4.
- Start while busy: pulse start at cycle 10 of a running frame -> no effect on the stream.
  - Exactly one done pulse; frame_cnt=1.
  - Back-to-back start in the cycle after returning to IDLE -> second frame is produced identically; frame_cnt=2.
- Abort: abort at cycle 8 (H_GAP=0) -> at most 2 further valid pixels after cycle 8.
  - done pulses once; busy then low; frame_cnt unchanged.
- Mid-frame reset: rst=1 at cycle 12 -> next edge valid=0, busy=0, mem_rd_en=0, frame_cnt=0, no done pulse.
  - Subsequent start produces a full, correct frame.
- Degenerate M=1, N=1: start -> a single valid pixel in cycle 3 with sof=1 and eol=1; done in cycle 4.

Source files
------------

// File: rtl/frame_pixel_streamer_pkg.sv
// Shared definitions for the raster pixel stream: FSM encoding, pixel width
// and the raster index used by both the streamer and the gradient windowing.
package pixel_stream_pkg;

  localparam int PIXEL_W = 8;
  localparam int GAP_W   = 8;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } stream_state_t;

  function automatic int raster_index(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/frame_pixel_streamer_if.sv
// Bundle of the sequencer handshake, frame buffer read port and pixel stream.
interface frame_pixel_streamer_if
  import pixel_stream_pkg::*;
#(
  parameter int ADDR_W = 5
) ();

  logic               start;
  logic               abort;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [PIXEL_W-1:0] mem_rdata;
  logic [PIXEL_W-1:0] pixel_out;
  logic               valid;
  logic               sof;
  logic               eol;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   frame_cnt;

  modport master (
    input  start, abort, mem_rdata,
    output mem_rd_en, mem_addr, pixel_out, valid, sof, eol, busy, done, frame_cnt
  );

  modport slave (
    output start, abort, mem_rdata,
    input  mem_rd_en, mem_addr, pixel_out, valid, sof, eol, busy, done, frame_cnt
  );

endinterface

// File: rtl/frame_pixel_streamer_raster_addr_counter.sv
// Row/column raster counter producing the frame buffer address row*N+col.
module raster_addr_counter
  import pixel_stream_pkg::*;
#(
  parameter int M      = 5,
  parameter int N      = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic              last_col,
  output logic              last_row,
  output logic [ADDR_W-1:0] addr
);

  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
  localparam int COL_W = (N > 1) ? $clog2(N) : 1;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  assign last_col = (col == COL_W'(N - 1));
  assign last_row = (row == ROW_W'(M - 1));
  assign addr     = ADDR_W'(raster_index(int'(row), int'(col), N));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Streams an M x N frame from a synchronous-read buffer in raster order with
// optional inter-row idle gaps, under a start/busy/done sequencer handshake.
module frame_pixel_streamer
  import pixel_stream_pkg::*;
#(
  parameter int M      = 5,
  parameter int N      = 5,
  parameter int ADDR_W = 5,
  parameter int H_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_pixel_streamer_if.master bus
);

  stream_state_t state, state_nxt;

  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] addr;
  logic              rd_issue;
  logic              cnt_clr;
  logic              busy_c;
  logic [GAP_W-1:0]  gap_cnt;
  logic              gap_done;
  logic              aborted;

  logic               vld_p0, sof_p0, eol_p0;
  logic               vld_p1, sof_p1, eol_p1;
  logic [PIXEL_W-1:0] pix_p1;
  logic               done_r;
  logic [CNT_W-1:0]   frame_cnt_r;

  raster_addr_counter #(
    .M      (M),
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .adv      (rd_issue),
    .last_col (last_col),
    .last_row (last_row),
    .addr     (addr)
  );

  assign gap_done = (gap_cnt == GAP_W'(H_GAP - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Abort takes priority over the row/frame boundary decisions in READ.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_READ;
      ST_READ: begin
        if (bus.abort)                           state_nxt = ST_DRAIN;
        else if (last_col && last_row)           state_nxt = ST_DRAIN;
        else if (last_col && (H_GAP > 0))        state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (bus.abort)     state_nxt = ST_DRAIN;
        else if (gap_done) state_nxt = ST_READ;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (state == ST_READ) && !bus.abort;
    busy_c   = (state != ST_IDLE);
    cnt_clr  = (state == ST_IDLE) || (state == ST_DRAIN) || (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)                              gap_cnt <= '0;
    else if (state == ST_GAP && !gap_done) gap_cnt <= gap_cnt + GAP_W'(1);
    else                                  gap_cnt <= '0;
  end

  // Remembers an abort so the completion edge pulses done without counting.
  always_ff @(posedge clk) begin
    if (rst)                  aborted <= 1'b0;
    else if (state == ST_IDLE) aborted <= 1'b0;
    else if ((state == ST_READ || state == ST_GAP) && bus.abort) aborted <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_r      <= 1'b0;
      frame_cnt_r <= '0;
    end else begin
      done_r <= (state == ST_DONE);
      if (state == ST_DONE && !aborted) frame_cnt_r <= frame_cnt_r + CNT_W'(1);
    end
  end

  // Stage p0: tags registered alongside the read, aligned with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      sof_p0 <= 1'b0;
      eol_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_issue;
      sof_p0 <= rd_issue && (addr == '0);
      eol_p0 <= rd_issue && last_col;
    end
  end

  // Stage p1: registered stream outputs; pixel holds while not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eol_p1 <= 1'b0;
      pix_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      sof_p1 <= sof_p0;
      eol_p1 <= eol_p0;
      if (vld_p0) pix_p1 <= bus.mem_rdata;
    end
  end

  assign bus.mem_rd_en = rd_issue;
  assign bus.mem_addr  = addr;
  assign bus.pixel_out = pix_p1;
  assign bus.valid     = vld_p1;
  assign bus.sof       = sof_p1;
  assign bus.eol       = eol_p1;
  assign bus.busy      = busy_c;
  assign bus.done      = done_r;
  assign bus.frame_cnt = frame_cnt_r;

endmodule
